// File: rtl/reset_release_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reset_release_sequencer                                      |
// | Description : Consumer of the fabric reset controller's active-low reset.  |
// |               Synchronises the fabric reset release into clk_i, then       |
// |               releases NUM_STAGES downstream active-low resets in order,   |
// |               stage 0 first. Each release is preceded by STAGE_DELAY       |
// |               cycles, and every stage after the first also waits for the   |
// |               previous stage's ready acknowledge. A software soft-reset    |
// |               request re-runs the whole sequence without a fabric reset.   |
// |                                                                            |
// | Ports       : clk_i             fabric clock, rising edge                  |
// |               fabric_reset_n_i  async active-low reset from controller     |
// |               soft_reset_req_i  sync level request to re-enter reset       |
// |               stage_ready_i     per-stage ready acknowledge (sync)         |
// |               stage_reset_n_o   sequenced active-low resets, bit i=stage i |
// |               all_ready_o       every stage released and acknowledged      |
// |               seq_fault_o       a stage failed to acknowledge in time      |
// |               fault_stage_o     index of the failing stage                 |
// |                                                                            |
// | Build option: RESET_SEQ_TIMEOUT_EN                                         |
// |               Defined   - WAIT gives up after TIMEOUT_CYCLES without       |
// |                           ready, enters FAULT and reports the stage.       |
// |               Undefined - WAIT waits indefinitely; seq_fault_o and         |
// |                           fault_stage_o are tied to 0.                     |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reset_release_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int STAGE_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  fabric_reset_n_i,
  input  logic                  soft_reset_req_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  output logic [NUM_STAGES-1:0] stage_reset_n_o,
  output logic                  all_ready_o,
  output logic                  seq_fault_o,
  output logic [2:0]            fault_stage_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Counter value on which a delay period ends (also the soft-reset
  // saturation point).
  localparam logic [15:0] c_delay_last = 16'(STAGE_DELAY - 1);
  // Index of the final stage in the chain.
  localparam logic [2:0]  c_last_idx   = 3'(NUM_STAGES - 1);
  // Largest value a 16-bit counter may hold before it saturates.
  localparam logic [15:0] c_cnt_max    = 16'hFFFF;

  // Elaboration-time sanity check of the configuration.
  generate
    if ((NUM_STAGES < 1) || (NUM_STAGES > 8) ||
        (STAGE_DELAY < 1) || (STAGE_DELAY > 65535) ||
        (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_params
      $error("reset_release_sequencer: parameter out of range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,  // waiting for the synchronised fabric reset release
    ST_DELAY = 3'd1,  // counting down before releasing stage idx
    ST_WAIT  = 3'd2,  // stage idx released, waiting for its ready
    ST_DONE  = 3'd3,  // every stage released and acknowledged
    ST_SOFT  = 3'd4   // software-requested reset in progress
`ifdef RESET_SEQ_TIMEOUT_EN
    ,
    ST_FAULT = 3'd5   // a stage failed to acknowledge; all stages held
`endif
  } state_e;

  // --------------------------------------------------------------------------
  // Reset synchroniser
  // --------------------------------------------------------------------------
  // Both flops clear asynchronously; the release propagates through two
  // clock edges so rst_sync rises on the second edge after deassertion.
  logic [1:0] sync_q;
  logic       rst_sync;

  always_ff @(posedge clk_i or negedge fabric_reset_n_i) begin
    if (!fabric_reset_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync = sync_q[1];

  // --------------------------------------------------------------------------
  // Sequencer registers
  // --------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_rst_n_q, stage_rst_n_d;
  logic                    all_ready_q, all_ready_d;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [15:0]  c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
  logic                    seq_fault_q, seq_fault_d;
  logic [2:0]              fault_stage_q, fault_stage_d;
`endif

  // Ready acknowledge of the stage currently being sequenced. Bits of stages
  // not yet released never reach the state logic.
  logic                    ready_sel;
  // Saturating increment of the shared counter.
  logic [15:0]             cnt_inc;

  assign cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : (cnt_q + 16'd1);

  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == 3'(i)) begin
        ready_sel = stage_ready_i[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    stage_rst_n_d = stage_rst_n_q;
    all_ready_d   = all_ready_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    seq_fault_d   = seq_fault_q;
    fault_stage_d = fault_stage_q;
`endif

    case (state_q)
      ST_RST: begin
        if (rst_sync) begin
          state_d = ST_DELAY;
          idx_d   = 3'd0;
          cnt_d   = 16'd0;
        end
      end

      ST_DELAY: begin
        if (cnt_q == c_delay_last) begin
          // Release only the stage being sequenced; earlier stages are
          // already high, so order can never be violated.
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == 3'(i)) begin
              stage_rst_n_d[i] = 1'b1;
            end
          end
          cnt_d   = 16'd0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT: begin
        // A ready arriving on the timeout edge still counts as success.
        if (ready_sel) begin
          if (idx_q == c_last_idx) begin
            state_d     = ST_DONE;
            all_ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = 16'd0;
            state_d = ST_DELAY;
          end
`ifdef RESET_SEQ_TIMEOUT_EN
        end else if (cnt_q == c_timeout_last) begin
          state_d       = ST_FAULT;
          stage_rst_n_d = '0;
          all_ready_d   = 1'b0;
          seq_fault_d   = 1'b1;
          fault_stage_d = idx_q;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end

      ST_DONE: begin
        // Outputs hold; later ready drops are deliberately ignored.
      end

      ST_SOFT: begin
        // Count up to the delay value and stay there, so that even a
        // single-cycle request holds all stages for STAGE_DELAY cycles.
        if (cnt_q == c_delay_last) begin
          if (!soft_reset_req_i) begin
            state_d = ST_DELAY;
            idx_d   = 3'd0;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

`ifdef RESET_SEQ_TIMEOUT_EN
      ST_FAULT: begin
        // Held until a soft reset or a fabric reset.
      end
`endif

      default: begin
        state_d = ST_RST;
      end
    endcase

    // A soft request overrides whatever the state logic decided on this
    // edge (ready or timeout included). While already in SOFT the request
    // only extends the hold, it does not restart the count.
    if (soft_reset_req_i && (state_q != ST_RST) && (state_q != ST_SOFT)) begin
      state_d       = ST_SOFT;
      cnt_d         = 16'd0;
      stage_rst_n_d = '0;
      all_ready_d   = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      seq_fault_d   = 1'b0;
      fault_stage_d = 3'd0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge fabric_reset_n_i) begin
    if (!fabric_reset_n_i) begin
      state_q       <= ST_RST;
      idx_q         <= 3'd0;
      cnt_q         <= 16'd0;
      stage_rst_n_q <= '0;
      all_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_rst_n_q <= stage_rst_n_d;
      all_ready_q   <= all_ready_d;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge fabric_reset_n_i) begin
    if (!fabric_reset_n_i) begin
      seq_fault_q   <= 1'b0;
      fault_stage_q <= 3'd0;
    end else begin
      seq_fault_q   <= seq_fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign seq_fault_o   = seq_fault_q;
  assign fault_stage_o = fault_stage_q;
`else
  assign seq_fault_o   = 1'b0;
  assign fault_stage_o = 3'd0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign stage_reset_n_o = stage_rst_n_q;
  assign all_ready_o     = all_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_release_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reset_release_sequencer                                   |
// | Description : Self-checking bench for reset_release_sequencer. Keeps an    |
// |               event-time model of the release schedule and compares all    |
// |               outputs on every falling clock edge.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reset_release_sequencer;

  localparam int N = 4;
  localparam int D = 16;
  localparam int T = 8;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [N-1:0] ready = '0;
  logic [N-1:0] stage_reset_n_o;
  logic         all_ready_o;
  logic         seq_fault_o;
  logic [2:0]   fault_stage_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_release_sequencer #(
    .NUM_STAGES    (N),
    .STAGE_DELAY   (D),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i           (clk),
    .fabric_reset_n_i(rst_n),
    .soft_reset_req_i(req),
    .stage_ready_i   (ready),
    .stage_reset_n_o (stage_reset_n_o),
    .all_ready_o     (all_ready_o),
    .seq_fault_o     (seq_fault_o),
    .fault_stage_o   (fault_stage_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks how many stages are released and the absolute
  // edge number at which the next event is due.
  // ---------------------------------------------------------------------------
  localparam int P_START = 0, P_COUNT = 1, P_WAITRDY = 2, P_DONE = 3, P_SOFT = 4, P_FAULT = 5;
  int m_phase = P_START;
  int m_age = 0;        // edges since fabric reset release
  int m_rel = 0;        // number of stages released
  bit m_all = 1'b0;
  bit m_fault = 1'b0;
  int m_fstage = 0;
  int m_target = 0;     // edge of next release
  int m_wstart = 0;     // edge on which the waited stage was released
  int m_soft_end = 0;   // earliest edge a soft reset may finish

  always @(posedge clk or negedge rst_n) begin
    int e;
    bit rs;
    if (!rst_n) begin
      m_phase = P_START; m_age = 0; m_rel = 0; m_all = 0; m_fault = 0; m_fstage = 0;
    end else begin
      e  = cyc + 1;
      rs = (m_age >= 2);
      if (m_age < 2) m_age++;
      if (m_phase == P_START) begin
        if (rs) begin m_phase = P_COUNT; m_target = e + D; end
      end else if (req && m_phase != P_SOFT) begin
        m_phase = P_SOFT; m_soft_end = e + D;
        m_rel = 0; m_all = 0; m_fault = 0; m_fstage = 0;
      end else begin
        case (m_phase)
          P_COUNT: if (e == m_target) begin m_rel++; m_phase = P_WAITRDY; m_wstart = e; end
          P_WAITRDY: begin
            if (ready[m_rel-1]) begin
              if (m_rel == N) begin m_phase = P_DONE; m_all = 1; end
              else begin m_phase = P_COUNT; m_target = e + D; end
            end else if (TO_EN && (e - m_wstart == T)) begin
              m_phase = P_FAULT; m_fstage = m_rel - 1; m_rel = 0; m_fault = 1;
            end
          end
          P_SOFT: if (e >= m_soft_end && !req) begin m_phase = P_COUNT; m_target = e + D; end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process plus rise-edge recorders (DUT and model).
  // ---------------------------------------------------------------------------
  int d_rise[N];
  int m_rise[N];
  int d_all_rise = -1, m_all_rise = -1, d_fault_rise = -1;
  logic [N-1:0] prev_mask = '0;
  int prev_rel = 0;
  bit prev_all = 0, prev_mall = 0, prev_fault = 0;

  always @(negedge clk) begin
    logic [N-1:0] em;
    em = '0;
    for (int i = 0; i < N; i++) if (i < m_rel) em[i] = 1'b1;
    chk("stage_reset_n", 32'(stage_reset_n_o), 32'(em));
    chk("all_ready", 32'(all_ready_o), 32'(m_all));
    chk("seq_fault", 32'(seq_fault_o), 32'(m_fault));
    chk("fault_stage", 32'(fault_stage_o), 32'(m_fstage));
    for (int i = 0; i < N; i++) begin
      if (stage_reset_n_o[i] && !prev_mask[i]) d_rise[i] = cyc;
      if (m_rel > i && prev_rel <= i) m_rise[i] = cyc;
    end
    if (all_ready_o && !prev_all) d_all_rise = cyc;
    if (m_all && !prev_mall) m_all_rise = cyc;
    if (seq_fault_o && !prev_fault) d_fault_rise = cyc;
    prev_mask = stage_reset_n_o; prev_rel = m_rel;
    prev_all = all_ready_o; prev_mall = m_all; prev_fault = seq_fault_o;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input int budget, input string nm);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      step();
      n++;
      case (sel)
        0: hit = all_ready_o;
        1: hit = stage_reset_n_o[1];
        2: hit = stage_reset_n_o[2];
        default: hit = seq_fault_o;
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_%s: not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic soft_pulse();
    step(); req = 1'b1;
    step(); req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, k, r, hold;
    for (int i = 0; i < N; i++) begin d_rise[i] = -1; m_rise[i] = -1; end

    // Power-up sequence, ready tied high.
    ready = '1;
    repeat (3) step();
    chk("reset_mask", 32'(stage_reset_n_o), 32'h0);
    chk("reset_all_ready", 32'(all_ready_o), 32'h0);
    rst_n = 1'b1; base = cyc;
    wait_for(0, 120, "all_ready_boot");
    chk("boot_rise0", 32'(d_rise[0] - base), 32'd19);
    chk("boot_rise1", 32'(d_rise[1] - base), 32'd36);
    chk("boot_rise2", 32'(d_rise[2] - base), 32'd53);
    chk("boot_rise3", 32'(d_rise[3] - base), 32'd70);
    chk("boot_all", 32'(d_all_rise - base), 32'd71);
    chk("model_rise0", 32'(m_rise[0] - base), 32'd19);
    chk("model_rise3", 32'(m_rise[3] - base), 32'd70);
    chk("model_all", 32'(m_all_rise - base), 32'd71);

    // One-cycle soft reset from DONE.
    soft_pulse();
    chk("soft_mask", 32'(stage_reset_n_o), 32'h0);
    chk("soft_all_ready", 32'(all_ready_o), 32'h0);
    wait_for(0, 200, "all_ready_soft");

`ifndef RESET_SEQ_TIMEOUT_EN
    // Stage 1 acknowledge withheld for 100 cycles.
    ready = 4'b1101;
    soft_pulse();
    wait_for(1, 200, "stage1");
    repeat (100) begin
      step();
      chk("stage2_held", 32'(stage_reset_n_o[2]), 32'h0);
    end
    ready[1] = 1'b1; k = cyc;
    wait_for(2, 60, "stage2");
    chk("stage2_gap", 32'(d_rise[2] - k), 32'd17);
    chk("model_stage2_gap", 32'(m_rise[2] - k), 32'd17);
`endif

    // Soft reset held for 40 cycles.
    ready = '1;
    soft_pulse();
    wait_for(0, 200, "all_ready_pre_hold");
    step(); req = 1'b1;
    repeat (40) begin
      step();
      chk("hold_mask", 32'(stage_reset_n_o), 32'h0);
    end
    req = 1'b0; k = cyc;
    wait_for(0, 200, "all_ready_hold");
    chk("hold_resume", 32'(d_rise[0] - k), 32'd17);

    // Fabric reset while waiting on stage 2.
    ready = 4'b1011;
    soft_pulse();
    wait_for(2, 200, "stage2_async");
    repeat (3) step();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_mask", 32'(stage_reset_n_o), 32'h0);
    chk("async_all_ready", 32'(all_ready_o), 32'h0);
    chk("async_fault", 32'(seq_fault_o), 32'h0);
    chk("async_fstage", 32'(fault_stage_o), 32'h0);
    step(); step();
    ready = '1;
    rst_n = 1'b1; base = cyc;
    wait_for(0, 120, "all_ready_restart");
    chk("restart_rise0", 32'(d_rise[0] - base), 32'd19);
    chk("restart_all", 32'(d_all_rise - base), 32'd71);

`ifdef RESET_SEQ_TIMEOUT_EN
    // Stage 2 never acknowledges.
    ready = 4'b1011;
    soft_pulse();
    wait_for(2, 200, "stage2_to");
    r = d_rise[2];
    wait_for(3, 30, "fault");
    chk("fault_delay", 32'(d_fault_rise - r), 32'd8);
    chk("fault_stage_idx", 32'(fault_stage_o), 32'd2);
    chk("fault_mask", 32'(stage_reset_n_o), 32'h0);
    soft_pulse();
    chk("fault_cleared", 32'(seq_fault_o), 32'h0);
    ready = '1;
    wait_for(0, 200, "all_ready_after_fault");
`endif

    // Randomised traffic against the model.
    hold = 0;
    for (int it = 0; it < 3000; it++) begin
      step();
      if ($urandom_range(0, 7) == 0)
        for (int b = 0; b < N; b++) ready[b] = ($urandom_range(0, 3) != 0);
      if (hold > 0) begin
        hold--;
        if (hold == 0) req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        req = 1'b1;
        hold = $urandom_range(1, 30);
      end
      if (!rst_n) begin
        if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
      end
    end
    req = 1'b0; rst_n = 1'b1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
